// File: rtl/fpu_f32_pkg.sv
// Shared F32 types and constants for the FPU conversion/arithmetic units.
package fpu_f32_pkg;

  localparam int          F32_BIAS      = 127;
  localparam logic [31:0] INT32_INVALID = 32'h8000_0000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } f32_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    SIGN,
    DONE
  } state_t;

endpackage

// File: rtl/fpu_f32_classify.sv
// Combinational F32 operand classifier: special-value flags, unbiased
// exponent and mantissa with the hidden bit restored.
module fpu_f32_classify
  import fpu_f32_pkg::*;
(
  input  f32_t              a,
  output logic              is_nan,
  output logic              is_inf,
  output logic              is_zero_or_denorm,
  output logic signed [9:0] e,
  output logic [23:0]       mant
);

  assign is_nan            = (a.exp == 8'hFF) && (a.frac != '0);
  assign is_inf            = (a.exp == 8'hFF) && (a.frac == '0);
  assign is_zero_or_denorm = (a.exp == 8'h00);
  assign e                 = signed'({2'b00, a.exp}) - 10'(F32_BIAS);
  assign mant              = {(a.exp != 8'h00), a.frac};

endmodule

// File: rtl/fpu_f32_to_int_iter.sv
// Multi-cycle F32 -> INT32 converter (C cast semantics, truncate toward zero).
// The mantissa is aligned SHIFT_STEP bits per cycle to keep the shifter narrow.
// Optional macro FPU_F32_TO_INT_ROUND_EN switches to round-to-nearest-even.
module fpu_f32_to_int_iter
  import fpu_f32_pkg::*;
#(
  parameter int SHIFT_STEP = 1
) (
  input  logic        MCLK,
  input  logic        RST,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] A,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] O,
  output logic        INVALID,
  output logic        INEXACT
);

  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

`ifdef FPU_F32_TO_INT_ROUND_EN
  // e = -1 still carries a possible round-up into bit 0
  localparam logic signed [9:0] E_MIN = -10'sd1;
`else
  localparam logic signed [9:0] E_MIN = 10'sd0;
`endif

  state_t      state;
  logic [31:0] w;
  logic [4:0]  remaining;
  logic        shift_left;
  logic        sign_q;
  logic        guard;
  logic        sticky;

  f32_t              a_f;
  logic              is_nan;
  logic              is_inf;
  logic              is_zero_or_denorm;
  logic signed [9:0] e;
  logic [23:0]       mant;

  assign a_f = A;

  fpu_f32_classify u_classify (
    .a                 (a_f),
    .is_nan            (is_nan),
    .is_inf            (is_inf),
    .is_zero_or_denorm (is_zero_or_denorm),
    .e                 (e),
    .mant              (mant)
  );

  // Accept-time decode: distance of the binary point from bit 23
  logic       acc_left;
  logic [4:0] acc_n;
  logic       acc_big;
  logic       acc_small;

  assign acc_left  = (e > 10'sd23);
  assign acc_n     = acc_left ? 5'(e - 10'sd23) : 5'(10'sd23 - e);
  assign acc_big   = (e >= 10'sd31);
  assign acc_small = is_zero_or_denorm || (e < E_MIN);

  assign IN_READY = (state == IDLE) && !RST;

  logic [4:0]  step_amt;
  logic [31:0] guard_mask;
  logic        guard_out;
  logic        below_out;
  logic        rnd_inc;
  logic [31:0] w_rnd;
  logic [31:0] o_sign;

`ifdef FPU_F32_TO_INT_ROUND_EN
  assign rnd_inc = guard && (sticky || w[0]);
`else
  assign rnd_inc = 1'b0;
`endif

  // Per-cycle shift amount, discarded-bit tracking and final signed result
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    step_amt   = (remaining > STEP) ? STEP : remaining;
    guard_mask = 32'd1 << (step_amt - 5'd1);
    guard_out  = |(w & guard_mask);
    below_out  = |(w & (guard_mask - 32'd1));
    w_rnd      = w + {31'd0, rnd_inc};
    o_sign     = sign_q ? (~w_rnd + 32'd1) : w_rnd;
  end

  // Control FSM with registered datapath and outputs
  always_ff @(posedge MCLK) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (RST) begin
      state      <= IDLE;
      w          <= '0;
      remaining  <= '0;
      shift_left <= 1'b0;
      sign_q     <= 1'b0;
      guard      <= 1'b0;
      sticky     <= 1'b0;
      O          <= '0;
      OUT_VALID  <= 1'b0;
      INVALID    <= 1'b0;
      INEXACT    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (IN_VALID) begin
            sign_q     <= a_f.sign;
            guard      <= 1'b0;
            sticky     <= 1'b0;
            w          <= {8'd0, mant};
            remaining  <= acc_n;
            shift_left <= acc_left;
            if (is_nan || is_inf) begin
              O         <= INT32_INVALID;
              INVALID   <= 1'b1;
              INEXACT   <= 1'b0;
              OUT_VALID <= 1'b1;
              state     <= DONE;
            end else if (acc_big) begin
              // -2^31 is the one exactly representable value in this range
              O         <= INT32_INVALID;
              INVALID   <= (A != 32'hCF00_0000);
              INEXACT   <= 1'b0;
              OUT_VALID <= 1'b1;
              state     <= DONE;
            end else if (acc_small) begin
              O         <= '0;
              INVALID   <= 1'b0;
              INEXACT   <= |A[30:0];
              OUT_VALID <= 1'b1;
              state     <= DONE;
            end else begin
              state <= (acc_n == 5'd0) ? SIGN : SHIFT;
            end
          end
        end
        SHIFT: begin
          if (shift_left) begin
            w <= w << step_amt;
          end else begin
            w      <= w >> step_amt;
            guard  <= guard_out;
            sticky <= sticky | guard | below_out;
          end
          remaining <= remaining - step_amt;
          if (remaining == step_amt) state <= SIGN;
        end
        SIGN: begin
          O         <= o_sign;
          INVALID   <= 1'b0;
          INEXACT   <= guard | sticky;
          OUT_VALID <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (OUT_READY) begin
            OUT_VALID <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_f32_to_int_iter.sv
// Self-checking bench for fpu_f32_to_int_iter: scoreboard of expected
// results, latency, backpressure, abort-by-reset and rounding cases.
module tb_fpu_f32_to_int_iter;

  logic        mclk;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, invalid, inexact;
  logic [31:0] a, o;
  logic        in_valid8, in_ready8, out_valid8, out_ready8, invalid8, inexact8;
  logic [31:0] a8, o8;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [31:0] o;
    logic        inv;
    logic        inex;
    int          lat;
  } exp_t;

  exp_t sb[$];

  fpu_f32_to_int_iter #(.SHIFT_STEP(1)) dut (
    .MCLK(mclk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready), .A(a),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .O(o),
    .INVALID(invalid), .INEXACT(inexact)
  );

  fpu_f32_to_int_iter #(.SHIFT_STEP(8)) dut8 (
    .MCLK(mclk), .RST(rst), .IN_VALID(in_valid8), .IN_READY(in_ready8), .A(a8),
    .OUT_VALID(out_valid8), .OUT_READY(out_ready8), .O(o8),
    .INVALID(invalid8), .INEXACT(inexact8)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input string name, input logic [31:0] eo, input logic inv,
                          input logic inex, input int lat);
    exp_t e;
    e.name = name; e.o = eo; e.inv = inv; e.inex = inex; e.lat = lat;
    sb.push_back(e);
  endtask

  // Present an operand for one edge (DUT expected idle) and record its expectation
  task automatic push_and_drive(input string name, input logic [31:0] val,
                                input logic [31:0] eo, input logic inv,
                                input logic inex, input int lat);
    push_exp(name, eo, inv, inex, lat);
    a = val;
    in_valid = 1'b1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s in_ready got=%b want=1", name, in_ready);
    end
    @(posedge mclk); #1;
    in_valid = 1'b0;
  endtask

  // Called #1 after the accept edge; waits for OUT_VALID and scores the result
  task automatic collect();
    exp_t e;
    int lat;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge mclk); #1;
      lat++;
    end
    e = sb.pop_front();
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s out_valid timeout got=%b want=1", e.name, out_valid);
    end
    total++;
    if (o !== e.o) begin
      bad++;
      $display("FAIL %s O got=%h want=%h", e.name, o, e.o);
    end
    total++;
    if (invalid !== e.inv) begin
      bad++;
      $display("FAIL %s INVALID got=%b want=%b", e.name, invalid, e.inv);
    end
    total++;
    if (inexact !== e.inex) begin
      bad++;
      $display("FAIL %s INEXACT got=%b want=%b", e.name, inexact, e.inex);
    end
    total++;
    if (lat != e.lat) begin
      bad++;
      $display("FAIL %s latency got=%0d want=%0d", e.name, lat, e.lat);
    end
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    @(posedge mclk); #1;
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s out_valid after handshake got=%b want=0", name, out_valid);
    end
  endtask

  task automatic run(input string name, input logic [31:0] val, input logic [31:0] eo,
                     input logic inv, input logic inex, input int lat);
    push_and_drive(name, val, eo, inv, inex, lat);
    collect();
    handshake(name);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; a = '0; out_ready = 1'b0;
    in_valid8 = 1'b0; a8 = '0; out_ready8 = 1'b0;
    repeat (2) @(posedge mclk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid got=%b want=0", out_valid); end
    total++;
    if (o !== 32'h0) begin bad++; $display("FAIL reset O got=%h want=0", o); end
    total++;
    if (invalid !== 1'b0 || inexact !== 1'b0) begin
      bad++; $display("FAIL reset flags got=%b%b want=00", invalid, inexact);
    end
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL reset in_ready_during got=%b want=0", in_ready); end
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset in_ready_after got=%b want=1", in_ready); end
  endtask

  task automatic test_normal();
    run("pi",       32'h40490FDB, 32'h0000_0003, 1'b0, 1'b1, 24);
    run("neg123",   32'hC2F60000, 32'hFFFF_FF85, 1'b0, 1'b0, 19);
    run("max_left", 32'h4EFFFFFF, 32'h7FFF_FF80, 1'b0, 1'b0, 9);
    run("neg_left", 32'hCEFFFFFF, 32'h8000_0080, 1'b0, 1'b0, 9);
    run("one",      32'h3F800000, 32'h0000_0001, 1'b0, 1'b0, 25);
    run("two23",    32'h4B000000, 32'h0080_0000, 1'b0, 1'b0, 2);
  endtask

  task automatic test_specials();
    run("nan",     32'h7FC00000, 32'h8000_0000, 1'b1, 1'b0, 1);
    run("ninf",    32'hFF800000, 32'h8000_0000, 1'b1, 1'b0, 1);
    run("p2_31",   32'h4F000000, 32'h8000_0000, 1'b1, 1'b0, 1);
    run("n2_31",   32'hCF000000, 32'h8000_0000, 1'b0, 1'b0, 1);
    run("negzero", 32'h80000000, 32'h0000_0000, 1'b0, 1'b0, 1);
    run("denorm",  32'h00000001, 32'h0000_0000, 1'b0, 1'b1, 1);
    run("quarter", 32'h3E800000, 32'h0000_0000, 1'b0, 1'b1, 1);
  endtask

  task automatic test_round();
`ifdef FPU_F32_TO_INT_ROUND_EN
    run("r1_5",  32'h3FC00000, 32'h0000_0002, 1'b0, 1'b1, 25);
    run("r2_5",  32'h40200000, 32'h0000_0002, 1'b0, 1'b1, 24);
    run("r0_5",  32'h3F000000, 32'h0000_0000, 1'b0, 1'b1, 26);
    run("r0_75", 32'h3F400000, 32'h0000_0001, 1'b0, 1'b1, 26);
    run("rm1_5", 32'hBFC00000, 32'hFFFF_FFFE, 1'b0, 1'b1, 25);
`else
    run("t1_5",  32'h3FC00000, 32'h0000_0001, 1'b0, 1'b1, 25);
    run("t2_5",  32'h40200000, 32'h0000_0002, 1'b0, 1'b1, 24);
    run("t0_5",  32'h3F000000, 32'h0000_0000, 1'b0, 1'b1, 1);
    run("t0_75", 32'h3F400000, 32'h0000_0000, 1'b0, 1'b1, 1);
    run("tm1_5", 32'hBFC00000, 32'hFFFF_FFFF, 1'b0, 1'b1, 25);
`endif
  endtask

  task automatic test_step8();
    exp_t e;
    int lat;
    push_exp("pi_step8", 32'h0000_0003, 1'b0, 1'b1, 5);
    a8 = 32'h40490FDB;
    in_valid8 = 1'b1;
    total++;
    if (in_ready8 !== 1'b1) begin bad++; $display("FAIL pi_step8 in_ready got=%b want=1", in_ready8); end
    @(posedge mclk); #1;
    in_valid8 = 1'b0;
    lat = 1;
    while (out_valid8 !== 1'b1 && lat < 200) begin
      @(posedge mclk); #1;
      lat++;
    end
    e = sb.pop_front();
    total++;
    if (o8 !== e.o) begin bad++; $display("FAIL %s O got=%h want=%h", e.name, o8, e.o); end
    total++;
    if (invalid8 !== e.inv || inexact8 !== e.inex) begin
      bad++; $display("FAIL %s flags got=%b%b want=%b%b", e.name, invalid8, inexact8, e.inv, e.inex);
    end
    total++;
    if (lat != e.lat) begin bad++; $display("FAIL %s latency got=%0d want=%0d", e.name, lat, e.lat); end
    out_ready8 = 1'b1;
    @(posedge mclk); #1;
    out_ready8 = 1'b0;
    total++;
    if (out_valid8 !== 1'b0) begin bad++; $display("FAIL pi_step8 handshake got=%b want=0", out_valid8); end
  endtask

  task automatic test_back_to_back();
    push_and_drive("bp_first", 32'hC2F60000, 32'hFFFF_FF85, 1'b0, 1'b0, 19);
    collect();
    // Next operand waits on the input while the result is held
    push_exp("bp_second", 32'h0000_0001, 1'b0, 1'b0, 25);
    a = 32'h3F800000;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge mclk); #1;
      total++;
      if (out_valid !== 1'b1 || o !== 32'hFFFF_FF85 || invalid !== 1'b0 || inexact !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold cyc%0d got v=%b O=%h f=%b%b want v=1 O=ffffff85 f=00",
                 i, out_valid, o, invalid, inexact);
      end
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc%0d got=%b want=0", i, in_ready); end
    end
    out_ready = 1'b1;
    @(posedge mclk); #1;
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
    @(posedge mclk); #1;
    in_valid = 1'b0;
    collect();
    handshake("bp_second");
  endtask

  task automatic test_abort();
    a = 32'h40490FDB;
    in_valid = 1'b1;
    @(posedge mclk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge mclk);
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL abort_busy got v=%b rdy=%b want v=0 rdy=0", out_valid, in_ready);
    end
    rst = 1'b1;
    @(posedge mclk); #1;
    rst = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL abort out_valid got=%b want=0", out_valid); end
    total++;
    if (o !== 32'h0) begin bad++; $display("FAIL abort O got=%h want=0", o); end
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL abort in_ready got=%b want=1", in_ready); end
    run("after_abort", 32'h3F800000, 32'h0000_0001, 1'b0, 1'b0, 25);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_specials();
    test_round();
    test_step8();
    test_back_to_back();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
